// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: operation codes (common with
// the ALU control decoder), the sequencing FSM states and small op helpers.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_e;

  // Shifts are the only ops that run on the iterative shifter.
  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

  // Codes above sra are not defined.
  function automatic logic is_legal(input logic [3:0] op);
    return op <= ALU_SRA;
  endfunction

endpackage

// File: rtl/alu_exec_unit_shifter.sv
// Iterative one-bit-per-cycle shifter. Loaded with the operand and shift
// amount, it steps once per cycle until the count reaches zero. dout is the
// value the accumulator takes after the current step, so when last is high
// dout already carries the finished result.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dir,    // 0: left, 1: right
  input  logic             arith,  // right shifts replicate the sign bit
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             last
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             arith_q, arith_d;
  logic [WIDTH-1:0] step;

  // One-bit shift of the accumulator in the latched direction.
  always_comb begin
    step = acc_q;
    if (dir_q) begin
      step = {arith_q & acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
    end else begin
      step = {acc_q[WIDTH-2:0], 1'b0};
    end
  end

  // Load a new job, otherwise keep stepping while bits remain.
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    arith_d = arith_q;
    if (load) begin
      acc_d   = din;
      cnt_d   = shamt;
      dir_d   = dir;
      arith_d = arith;
    end else if (cnt_q != '0) begin
      acc_d = step;
      cnt_d = cnt_q - SHW'(1);
    end
  end

  // Shifter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      arith_q <= arith_d;
    end
  end

  assign dout = step;
  assign last = (cnt_q == SHW'(1));

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU. Logic, add/sub and compares finish at the accepting
// edge; shifts are handed to the iterative shifter. Results, zero and illegal
// flags are registered and held in DONE until the downstream takes them.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;

  logic             sh_load;
  logic [WIDTH-1:0] sh_dout;
  logic             sh_last;
  logic [SHW-1:0]   shamt;

  assign shamt = op_b[SHW-1:0];

  // Single-cycle datapath. A shift only lands here when its amount is zero,
  // in which case the result is operand A unchanged.
  function automatic logic [WIDTH-1:0] alu_compute(input logic [3:0]       op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic [WIDTH-1:0]        r;
    sa = a;
    sb = b;
    case (op)
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_ADD:  r = a + b;
      ALU_XOR:  r = a ^ b;
      ALU_SUB:  r = a - b;
      ALU_SLTU: r = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_SLT:  r = {{(WIDTH-1){1'b0}}, (sa < sb)};
      ALU_SLL, ALU_SRL, ALU_SRA: r = a;
      default:  r = '0;
    endcase
    return r;
  endfunction

  alu_shifter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_shifter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (sh_load),
    .dir   (alu_op != ALU_SLL),
    .arith (alu_op == ALU_SRA),
    .shamt (shamt),
    .din   (op_a),
    .dout  (sh_dout),
    .last  (sh_last)
  );

  // Next-state and result capture; flush overrides every other transition.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    sh_load   = 1'b0;
    if (flush) begin
      state_d   = IDLE;
      result_d  = '0;
      zero_d    = 1'b0;
      illegal_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (is_shift(alu_op) && (shamt != '0)) begin
              sh_load = 1'b1;
              state_d = SHIFT;
            end else begin
              result_d  = alu_compute(alu_op, op_a, op_b);
              zero_d    = (result_d == '0);
              illegal_d = !is_legal(alu_op);
              state_d   = DONE;
            end
          end
        end
        SHIFT: begin
          if (sh_last) begin
            result_d  = sh_dout;
            zero_d    = (sh_dout == '0);
            illegal_d = 1'b0;
            state_d   = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit (WIDTH = 64): directed corner cases
// followed by randomized operations against a behavioural reference model.
module tb_alu_exec_unit;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   alu_op = 4'd0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero;
  logic         illegal;

  int n_tests = 0;
  int n_fail  = 0;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Reference model: RISC-V style ALU semantics with plain operators.
  function automatic logic [W-1:0] ref_result(input logic [3:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    int sh;
    sh = int'(b[5:0]);
    case (op)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: return a + b;
      4'd3: return a ^ b;
      4'd4: return a << sh;
      4'd5: return a >> sh;
      4'd6: return a - b;
      4'd7: return (a < b) ? 64'd1 : 64'd0;
      4'd8: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'd9: return $unsigned($signed(a) >>> sh);
      default: return 64'd0;
    endcase
  endfunction

  // Cycles spent in SHIFT after the accepting edge: the shift amount for a
  // shift with non-zero amount, none for everything else.
  function automatic int ref_shift_cycles(input logic [3:0] op, input logic [W-1:0] b);
    if ((op == 4'd4 || op == 4'd5 || op == 4'd9) && b[5:0] != 6'd0) return int'(b[5:0]);
    return 0;
  endfunction

  // Offer one op, check latency and outputs, hold it for 'hold' cycles, then consume.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int hold);
    logic [W-1:0] exp_r;
    int exp_lat, waited;
    exp_r   = ref_result(op, a, b);
    exp_lat = ref_shift_cycles(op, b);
    waited  = 0;
    while (!in_ready && waited < 200) begin
      @(posedge clk); #1; waited++;
    end
    check({tag, " in_ready"}, 64'(in_ready), 64'd1);
    alu_op = op; op_a = a; op_b = b; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    alu_op = 4'($urandom()); op_a = rnd64(); op_b = rnd64();
    waited = 0;
    while (!out_valid && waited < 200) begin
      @(posedge clk); #1; waited++;
    end
    check({tag, " latency"}, 64'(waited), 64'(exp_lat));
    check({tag, " result"}, result, exp_r);
    check({tag, " zero"}, 64'(zero), 64'(exp_r == 64'd0));
    check({tag, " illegal"}, 64'(illegal), 64'(op > 4'd9));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " held"}, result, exp_r);
      check({tag, " held in_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " consumed"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [3:0] rop;
    logic [W-1:0] ra, rb;
    int seen;

    // Reset state
    #12;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset result", result, 64'd0);
    check("reset zero", 64'(zero), 64'd0);
    check("reset illegal", 64'(illegal), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Arithmetic corners
    run_op("add wrap", 4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
    run_op("sub 5-5", 4'd6, 64'd5, 64'd5, 0);
    run_op("slt -1<1", 4'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
    run_op("sltu -1<1", 4'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
    run_op("sra 3", 4'd9, 64'h8000_0000_0000_0000, 64'h43, 0);
    check("sra 3 value", ref_result(4'd9, 64'h8000_0000_0000_0000, 64'h43), 64'hF000_0000_0000_0000);
    run_op("sll 0", 4'd4, 64'h1234_5678_9ABC_DEF0, 64'h40, 0);
    run_op("illegal", 4'b1100, rnd64(), rnd64(), 0);
    run_op("srl 63", 4'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd63, 0);

    // Backpressure with a competing request offered while DONE is held
    run_op("bp", 4'd3, 64'h00FF_00FF_00FF_00FF, 64'h0F0F_0F0F_0F0F_0F0F, 5);
    alu_op = 4'd2; op_a = 64'd10; op_b = 64'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    check("bp second accepted", 64'(out_valid), 64'd1);
    check("bp second result", result, 64'd30);
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      in_valid = 1'b1; alu_op = 4'd0;
      check("bp no accept while held", result, 64'd30);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp idle after consume", 64'(in_ready), 64'd1);
    check("bp not accepted same edge", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp accepted next", 64'(out_valid), 64'd1);
    check("bp next result", result, 64'd0 & 64'd20);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Flush during a long srl with a simultaneous request
    alu_op = 4'd5; op_a = rnd64(); op_b = 64'd40; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1; alu_op = 4'd2; op_a = 64'd1; op_b = 64'd2;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush in_ready", 64'(in_ready), 64'd1);
    check("flush out_valid", 64'(out_valid), 64'd0);
    seen = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    check("flush no result", 64'(seen), 64'd0);
    run_op("after flush", 4'd1, 64'hA0, 64'h0B, 0);

    // Asynchronous reset in the middle of a shift
    alu_op = 4'd4; op_a = rnd64() | 64'd1; op_b = 64'd50; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst in_ready", 64'(in_ready), 64'd1);
    check("async rst out_valid", 64'(out_valid), 64'd0);
    check("async rst result", result, 64'd0);
    check("async rst zero", 64'(zero), 64'd0);
    check("async rst illegal", 64'(illegal), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("async rst no partial", 64'(seen), 64'd0);

    // Randomized operations
    for (int n = 0; n < 200; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = rnd64();
      rb  = rnd64();
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: ra = {1'b1, ra[W-2:0]};
        default: ;
      endcase
      run_op("rand", rop, ra, rb, int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule
